// File: rtl/clock_pkg.sv
// Shared time-of-day limits and value type, reused by the digit-split
// stage and the calendar counter.
package clock_pkg;
  localparam int TIME_W = 8;
  typedef logic [TIME_W-1:0] time_val_t;
  localparam time_val_t SEC_MAX  = 8'd59;
  localparam time_val_t MIN_MAX  = 8'd59;
  localparam time_val_t HOUR_MAX = 8'd23;
endpackage

// File: rtl/time_of_day_counter_tick_gen.sv
// Prescaler: divides clk down to a one-cycle tick every CLK_HZ cycles.
// hold pins the count at 0, so the next tick is a full period after release.
module tick_gen #(
  parameter int CLK_HZ = 50000000,
  parameter int CNT_W  = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !hold && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (hold || cnt == LAST) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/time_of_day_counter.sv
// Seconds/minutes/hours time base with manual set mode and a day-rollover
// pulse for the calendar counter. Mode is set_en directly; no state register.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int CNT_W  = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic              inc_min,
  input  logic              inc_hour,
  output logic [TIME_W-1:0] seconds,
  output logic [TIME_W-1:0] minutes,
  output logic [TIME_W-1:0] hours,
  output logic              sec_tick,
  output logic              day_tick
);
  logic tick;
  logic sec_last, min_last, hour_last;

  tick_gen #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) u_tick (
    .clk  (clk),
    .reset(reset),
    .hold (set_en),
    .tick (tick)
  );

  assign sec_last  = (seconds == SEC_MAX);
  assign min_last  = (minutes == MIN_MAX);
  assign hour_last = (hours   == HOUR_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seconds  <= '0;
      minutes  <= '0;
      hours    <= '0;
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      if (set_en) begin
        // Set mode: minute and hour wrap independently, never carry.
        seconds <= '0;
        if (inc_min)  minutes <= min_last  ? '0 : minutes + 1'b1;
        if (inc_hour) hours   <= hour_last ? '0 : hours + 1'b1;
      end else if (tick) begin
        sec_tick <= 1'b1;
        if (!sec_last) begin
          seconds <= seconds + 1'b1;
        end else begin
          seconds <= '0;
          if (!min_last) begin
            minutes <= minutes + 1'b1;
          end else begin
            minutes <= '0;
            if (!hour_last) begin
              hours <= hours + 1'b1;
            end else begin
              hours    <= '0;
              day_tick <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench: stimulus drives at negedge and queues the expected
// post-edge outputs from a seconds-of-day model; monitor compares after posedge.
module tb_time_of_day_counter;
  localparam int CLK_HZ = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       set_en = 1'b0, inc_min = 1'b0, inc_hour = 1'b0;
  logic [7:0] seconds, minutes, hours;
  logic       sec_tick, day_tick;

  typedef struct {
    int s, m, h;
    bit st, dt;
  } exp_t;

  exp_t q[$];
  int vectors = 0, miscompares = 0, dayc = 0;
  int tod = 0;    // seconds since midnight
  int phase = 0;  // clk cycles since the last second boundary

  always #5 clk = ~clk;

  time_of_day_counter #(.CLK_HZ(CLK_HZ), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .set_en(set_en), .inc_min(inc_min),
    .inc_hour(inc_hour), .seconds(seconds), .minutes(minutes),
    .hours(hours), .sec_tick(sec_tick), .day_tick(day_tick)
  );

  function automatic exp_t model(input bit se, input bit im, input bit ih);
    exp_t e;
    int h, m;
    e.st = 0; e.dt = 0;
    if (se) begin
      phase = 0;
      h = tod / 3600;
      m = (tod / 60) % 60;
      if (im) m = (m + 1) % 60;
      if (ih) h = (h + 1) % 24;
      tod = h * 3600 + m * 60;
    end else if (phase == CLK_HZ - 1) begin
      phase = 0;
      tod = (tod + 1) % 86400;
      e.st = 1;
      e.dt = (tod == 0);
    end else begin
      phase++;
    end
    e.s = tod % 60;
    e.m = (tod / 60) % 60;
    e.h = tod / 3600;
    return e;
  endfunction

  task automatic step(input bit se, input bit im, input bit ih);
    set_en = se; inc_min = im; inc_hour = ih;
    q.push_back(model(se, im, ih));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic pulses(input int n, input bit im, input bit ih);
    for (int i = 0; i < n; i++) begin
      step(1, im, ih);
      step(1, 0, 0);
    end
  endtask

  // Asynchronous reset between edges, checked before any further clk edge.
  task automatic reset_pulse();
    set_en = 0; inc_min = 0; inc_hour = 0;
    q.push_back(model(0, 0, 0));
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({seconds, minutes, hours, sec_tick, day_tick} !== 26'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %0d:%0d:%0d st=%0b dt=%0b, want all 0",
               hours, minutes, seconds, sec_tick, day_tick);
    end
    reset = 1'b0;
    tod = 0;
    phase = 0;
    @(negedge clk);
  endtask

  task automatic check_dayc(input string name, input int want);
    vectors++;
    if (dayc != want) begin
      miscompares++;
      $display("FAIL %s: day_tick pulses %0d, want %0d", name, dayc, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (day_tick === 1'b1) dayc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (seconds !== 8'(e.s) || minutes !== 8'(e.m) || hours !== 8'(e.h) ||
            sec_tick !== e.st || day_tick !== e.dt) begin
          miscompares++;
          $display("FAIL cycle_out @%0t: got %0d:%0d:%0d st=%0b dt=%0b, want %0d:%0d:%0d st=%0b dt=%0b",
                   $time, hours, minutes, seconds, sec_tick, day_tick,
                   e.h, e.m, e.s, e.st, e.dt);
        end
      end
    end
  end

  initial begin : stim
    bit se;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // first tick, period, and 00:00:00 -> 00:01:00
    run(600);
    // set to 23:59:00, then hour wrap must not raise day_tick
    dayc = 0;
    pulses(23, 0, 1);
    pulses(58, 1, 0);
    pulses(1, 0, 1);
    check_dayc("set_hour_wrap", 0);
    // back to 23:59:00 and let it roll over midnight
    pulses(23, 0, 1);
    dayc = 0;
    run(600);
    check_dayc("midnight_roll", 1);
    // 10:20 then joint pulses in set mode and run mode
    pulses(10, 0, 1);
    pulses(20, 1, 0);
    pulses(1, 1, 1);
    step(0, 1, 1);
    run(4);
    // 12:34:56 then mid-count async reset
    pulses(1, 0, 1);
    pulses(13, 1, 0);
    run(563);
    reset_pulse();
    run(25);
    // randomized mode switching and pulses
    se = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) se = ~se;
      step(se, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end
    run(15);
    @(posedge clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: %0d left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
